friscv_irq_arbiter: RTL and testbench
=====================================

Name: friscv_irq_arbiter

Overview:
- Sits directly downstream of the core-local interrupt controller (sw_irq, timer_irq) and also takes the external interrupt line.
- Registers the sources into an mip image and masks them with mie and mstatus.MIE.
- Selects one interrupt by fixed priority and presents it to the control unit as a trap request over a valid/ready handshake.
- After a request is accepted, blocks further requests until the handler returns with mret.

Parameters:
- XLEN, 32, architecture width; sets the width of mip, mie and irq_cause.
- EXT_SYNC, 1: two-flop synchronizer on ext_irq. 0: ext_irq is registered once, like the other sources.

Ports:
- aclk  in  1  clock.
- srst  in  1  synchronous, active-low reset.
- sw_irq  in  1  machine software interrupt, level, from the core-local interrupt controller.
- timer_irq  in  1  machine timer interrupt, level, from the core-local interrupt controller.
- ext_irq  in  1  machine external interrupt, level, may be asynchronous.
- mstatus_mie  in  1  global machine interrupt enable.
- mie  in  XLEN  machine interrupt-enable CSR value.
- mret  in  1  single-cycle pulse when the core retires mret.
- mip  out  XLEN  pending image; bit 3 = MSIP, bit 7 = MTIP, bit 11 = MEIP, all other bits 0.
- irq_valid  out  1  trap request.
- irq_ready  in  1  control unit accepts the trap.
- irq_cause  out  XLEN  mcause value: bit XLEN-1 = 1, low bits = exception code, all other bits 0.
- in_trap  out  1  high from handshake until mret.
- irq_count  out  32  number of accepted interrupts; wraps.

Behaviour:
- Reset (srst=0 at a rising edge):
  - mip=0, irq_valid=0, irq_cause=0, in_trap=0, irq_count=0.
  - Synchronizer flops cleared; FSM to IDLE.
  - Reset asserted in any state aborts the operation; no handshake completes on that edge.
- Pending capture, level-sensitive:
  - mip[3] <= sw_irq and mip[7] <= timer_irq each cycle, giving 1-cycle latency.
  - mip[11] follows ext_irq with 3-cycle latency when EXT_SYNC=1, 1-cycle when EXT_SYNC=0.
  - Deasserting a source clears its mip bit with the same latency.
- enabled = mip & mie & {XLEN{mstatus_mie}}, combinational.
- Priority: MEI (code 11) > MSI (code 3) > MTI (code 7).
- FSM states: IDLE, REQ, TRAP.
  - IDLE: if enabled is nonzero, capture irq_cause from the highest-priority enabled bit, go to REQ, and set irq_valid=1 on the same edge. With srst=1, sw_irq rising at edge N gives mip[3]=1 after N+1 and irq_valid=1 after N+2.
  - REQ: irq_valid and irq_cause are held stable until irq_valid and irq_ready are both high at an edge. No retraction, even if the source, mie or mstatus_mie drops meanwhile.
  - A higher-priority interrupt arriving while in REQ does not change irq_cause.
  - On handshake: irq_valid=0, in_trap=1, irq_count+1 (wraps 0xFFFFFFFF to 0), go to TRAP.
  - TRAP: no request is issued. On mret: in_trap=0, go to IDLE. A new request can appear on the edge after IDLE is re-entered, so the minimum gap is 1 cycle in IDLE.
  - mret in IDLE or REQ is ignored.
  - irq_ready in IDLE or TRAP is ignored.
- mip keeps tracking its sources in every state.
- irq_cause keeps its last captured value outside REQ; it is only meaningful while irq_valid=1.

Decomposition:
- friscv_h package holds:
  - Bit-position constants MSIP_BIT=3, MTIP_BIT=7, MEIP_BIT=11.
  - Codes IRQ_CODE_MSI=3, IRQ_CODE_MTI=7, IRQ_CODE_MEI=11.
  - The FSM state enum type.
- One sub-module, friscv_bit_sync: a parameterizable N-flop synchronizer with synchronous active-low reset to 0, used for ext_irq.

Test Plan:
- Reset check: after reset release, mip=0, irq_valid=0, in_trap=0, irq_count=0. Drive sw_irq=1 with mie[3]=1 and mstatus_mie=1 → mip=0x8 after 1 cycle, irq_valid=1 with irq_cause=0x80000003 after 2 cycles.
- Simultaneous sources: sw_irq, timer_irq and ext_irq all=1 with mie=0x888 → irq_cause=0x8000000B. After handshake and mret, with ext_irq=0 → 0x80000003. After a second mret, with sw_irq=0 → 0x80000007. irq_count=3.
- Masking: timer_irq=1, mie=0x80, mstatus_mie=0 → mip=0x80 and no irq_valid for 20 cycles. Set mstatus_mie=1 → irq_valid=1 with irq_cause=0x80000007 exactly one cycle later.
- Stall and stability: hold irq_ready=0 for 10 cycles and drop timer_irq in the middle → irq_valid and irq_cause stay unchanged. Pulse irq_ready → in_trap=1 on the next cycle. Pulse mret → in_trap=0.
- Reset mid-operation: assert srst=0 while in REQ, with irq_ready=1 on the same edge → irq_valid=0, in_trap=0, irq_count unchanged at 0.
- Counter wrap and protocol: force 2^32 accepted interrupts (shortened with a forced counter preload) → irq_count reads 0. mret issued in IDLE has no effect.

Source files
------------

// File: rtl/friscv_irq_arbiter_pkg.sv
// Shared constants, FSM state type and priority encoder for the machine-mode interrupt arbiter.
// Bit positions follow the RISC-V mip/mie layout; codes are the mcause exception codes.
package friscv_h;

    localparam int MSIP_BIT = 3;
    localparam int MTIP_BIT = 7;
    localparam int MEIP_BIT = 11;

    localparam int IRQ_CODE_MSI = 3;
    localparam int IRQ_CODE_MTI = 7;
    localparam int IRQ_CODE_MEI = 11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        TRAP = 2'd2
    } irq_state_e;

    // Fixed priority: external > software > timer.
    function automatic logic [3:0] irq_code(input logic mei, input logic msi, input logic mti);
        if (mei)      return 4'(IRQ_CODE_MEI);
        else if (msi) return 4'(IRQ_CODE_MSI);
        else if (mti) return 4'(IRQ_CODE_MTI);
        else          return 4'd0;
    endfunction

endpackage

// File: rtl/friscv_bit_sync.sv
// N-flop level synchronizer, synchronous active-low reset to 0.
// Latency STAGES cycles; no backpressure (free-running shift chain).
module friscv_bit_sync #(
    parameter int STAGES = 2
) (
    input  logic aclk,
    input  logic srst,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge aclk) begin
        if (!srst) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/friscv_irq_arbiter.sv
// Machine interrupt arbiter: registers sources into mip, masks, picks one by fixed priority and
// issues it as a valid/ready trap request (1 cycle after mip); request held until ready, then blocked until mret.
module friscv_irq_arbiter
    import friscv_h::*;
#(
    parameter int XLEN     = 32,
    parameter int EXT_SYNC = 1
) (
    input  logic            aclk,
    input  logic            srst,
    input  logic            sw_irq,
    input  logic            timer_irq,
    input  logic            ext_irq,
    input  logic            mstatus_mie,
    input  logic [XLEN-1:0] mie,
    input  logic            mret,
    output logic [XLEN-1:0] mip,
    output logic            irq_valid,
    input  logic            irq_ready,
    output logic [XLEN-1:0] irq_cause,
    output logic            in_trap,
    output logic [31:0]     irq_count
);

    irq_state_e      state_q, state_d;
    logic [XLEN-1:0] mip_q, mip_d;
    logic [XLEN-1:0] cause_q, cause_d;
    logic [31:0]     irq_count_q, irq_count_d;
    logic [XLEN-1:0] enabled;
    logic [3:0]      code;
    logic            ext_lvl;

    generate
        if (EXT_SYNC != 0) begin : g_ext_sync
            friscv_bit_sync #(.STAGES(2)) u_ext_sync (
                .aclk (aclk),
                .srst (srst),
                .d_i  (ext_irq),
                .q_o  (ext_lvl)
            );
        end else begin : g_ext_direct
            assign ext_lvl = ext_irq;
        end
    endgenerate

    always_comb begin
        mip_d           = '0;
        mip_d[MSIP_BIT] = sw_irq;
        mip_d[MTIP_BIT] = timer_irq;
        mip_d[MEIP_BIT] = ext_lvl;
    end

    assign enabled = mip_q & mie & {XLEN{mstatus_mie}};
    assign code    = irq_code(enabled[MEIP_BIT], enabled[MSIP_BIT], enabled[MTIP_BIT]);

    always_ff @(posedge aclk) begin
        if (!srst) begin
            state_q     <= IDLE;
            mip_q       <= '0;
            cause_q     <= '0;
            irq_count_q <= '0;
        end else begin
            state_q     <= state_d;
            mip_q       <= mip_d;
            cause_q     <= cause_d;
            irq_count_q <= irq_count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|enabled) state_d = REQ;
            REQ:     if (irq_ready) state_d = TRAP;
            TRAP:    if (mret) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Cause is only captured when leaving IDLE, so a later higher-priority source cannot retarget a pending request.
    always_comb begin
        cause_d     = cause_q;
        irq_count_d = irq_count_q;
        if (state_q == IDLE && |enabled) begin
            cause_d = {1'b1, {(XLEN-5){1'b0}}, code};
        end
        if (state_q == REQ && irq_ready) begin
            irq_count_d = irq_count_q + 32'd1;
        end
    end

    always_comb begin
        irq_valid = (state_q == REQ);
        in_trap   = (state_q == TRAP);
    end

    assign mip       = mip_q;
    assign irq_cause = cause_q;
    assign irq_count = irq_count_q;

endmodule

// File: tb/tb_friscv_irq_arbiter.sv
// Bench for friscv_irq_arbiter: directed scenarios plus random traffic, checked against
// a cycle-level reference model with a cause scoreboard.
module tb_friscv_irq_arbiter;

    logic        aclk = 1'b0;
    logic        srst = 1'b0;
    logic        sw_irq = 1'b0, timer_irq = 1'b0, ext_irq = 1'b0;
    logic        mstatus_mie = 1'b0;
    logic [31:0] mie = '0;
    logic        mret = 1'b0;
    logic [31:0] mip;
    logic        irq_valid;
    logic        irq_ready = 1'b0;
    logic [31:0] irq_cause;
    logic        in_trap;
    logic [31:0] irq_count;

    int n_vec = 0;
    int n_err = 0;

    always #5 aclk = ~aclk;

    friscv_irq_arbiter #(.XLEN(32), .EXT_SYNC(1)) dut (
        .aclk        (aclk),
        .srst        (srst),
        .sw_irq      (sw_irq),
        .timer_irq   (timer_irq),
        .ext_irq     (ext_irq),
        .mstatus_mie (mstatus_mie),
        .mie         (mie),
        .mret        (mret),
        .mip         (mip),
        .irq_valid   (irq_valid),
        .irq_ready   (irq_ready),
        .irq_cause   (irq_cause),
        .in_trap     (in_trap),
        .irq_count   (irq_count)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: pending image with per-source delay, one outstanding request, trap flag.
    logic [31:0] m_mip   = '0;
    logic        m_e1    = 1'b0, m_e2 = 1'b0;
    logic        m_req   = 1'b0;
    logic        m_trap  = 1'b0;
    logic [31:0] m_cause = '0;
    logic [31:0] m_count = '0;
    logic [31:0] exp_q[$];

    always @(posedge aclk) begin : model
        logic [31:0] en;
        if (!srst) begin
            m_mip = '0; m_e1 = 1'b0; m_e2 = 1'b0;
            m_req = 1'b0; m_trap = 1'b0; m_count = '0; m_cause = '0;
        end else begin
            en = m_mip & mie & {32{mstatus_mie}};
            if (m_trap) begin
                if (mret) m_trap = 1'b0;
            end else if (m_req) begin
                if (irq_ready) begin
                    m_req = 1'b0;
                    m_trap = 1'b1;
                    m_count = m_count + 1;
                end
            end else if (en != 0) begin
                m_req = 1'b1;
                m_cause = 32'h8000_0000 + (en[11] ? 32'd11 : en[3] ? 32'd3 : 32'd7);
                exp_q.push_back(m_cause);
            end
            m_mip     = '0;
            m_mip[3]  = sw_irq;
            m_mip[7]  = timer_irq;
            m_mip[11] = m_e2;
            m_e2      = m_e1;
            m_e1      = ext_irq;
        end
    end

    logic prev_vld = 1'b0;

    always @(negedge aclk) begin : monitor
        logic [31:0] c;
        chk("mip", mip, m_mip);
        chk("irq_valid", {31'b0, irq_valid}, {31'b0, m_req});
        chk("in_trap", {31'b0, in_trap}, {31'b0, m_trap});
        chk("irq_count", irq_count, m_count);
        if (irq_valid && !prev_vld) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_request: cause %h with empty scoreboard", irq_cause);
            end else begin
                c = exp_q.pop_front();
                chk("irq_cause_new", irq_cause, c);
            end
        end
        if (m_req) chk("irq_cause_hold", irq_cause, m_cause);
        prev_vld = irq_valid;
    end

    task automatic tick;
        @(posedge aclk);
        #2;
    endtask

    task automatic do_reset;
        srst = 1'b0;
        sw_irq = 1'b0; timer_irq = 1'b0; ext_irq = 1'b0;
        mstatus_mie = 1'b0; mie = '0; mret = 1'b0; irq_ready = 1'b0;
        repeat (2) tick();
        srst = 1'b1;
        tick();
    endtask

    task automatic handshake;
        irq_ready = 1'b1;
        tick();
        irq_ready = 1'b0;
    endtask

    task automatic do_mret;
        mret = 1'b1;
        tick();
        mret = 1'b0;
    endtask

    initial begin
        // Reset state and single software interrupt
        do_reset();
        chk("rst_mip", mip, 32'h0);
        chk("rst_valid", {31'b0, irq_valid}, 32'h0);
        chk("rst_in_trap", {31'b0, in_trap}, 32'h0);
        chk("rst_count", irq_count, 32'h0);
        sw_irq = 1'b1; mie = 32'h8; mstatus_mie = 1'b1;
        tick();
        chk("msi_mip", mip, 32'h8);
        chk("msi_valid_early", {31'b0, irq_valid}, 32'h0);
        tick();
        chk("msi_valid", {31'b0, irq_valid}, 32'h1);
        chk("msi_cause", irq_cause, 32'h8000_0003);
        handshake();
        chk("msi_in_trap", {31'b0, in_trap}, 32'h1);
        chk("msi_count", irq_count, 32'h1);
        sw_irq = 1'b0;
        do_mret();
        chk("msi_mret", {31'b0, in_trap}, 32'h0);
        tick();
        chk("msi_quiet", {31'b0, irq_valid}, 32'h0);

        // Simultaneous sources resolved by priority
        do_reset();
        sw_irq = 1'b1; timer_irq = 1'b1; ext_irq = 1'b1; mie = 32'h888; mstatus_mie = 1'b0;
        repeat (5) tick();
        mstatus_mie = 1'b1;
        tick();
        chk("prio_mei", irq_cause, 32'h8000_000B);
        handshake();
        ext_irq = 1'b0;
        repeat (4) tick();
        do_mret();
        tick();
        chk("prio_msi", irq_cause, 32'h8000_0003);
        handshake();
        sw_irq = 1'b0;
        repeat (2) tick();
        do_mret();
        tick();
        chk("prio_mti", irq_cause, 32'h8000_0007);
        handshake();
        chk("prio_count", irq_count, 32'd3);
        timer_irq = 1'b0;
        repeat (2) tick();
        do_mret();
        tick();

        // Global mask holds off the request
        do_reset();
        timer_irq = 1'b1; mie = 32'h80; mstatus_mie = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("mask_no_valid", {31'b0, irq_valid}, 32'h0);
        end
        chk("mask_mip", mip, 32'h80);
        mstatus_mie = 1'b1;
        tick();
        chk("unmask_valid", {31'b0, irq_valid}, 32'h1);
        chk("unmask_cause", irq_cause, 32'h8000_0007);

        // Stall: request and cause stay put while the source drops
        for (int i = 0; i < 10; i++) begin
            if (i == 5) timer_irq = 1'b0;
            tick();
            chk("stall_valid", {31'b0, irq_valid}, 32'h1);
            chk("stall_cause", irq_cause, 32'h8000_0007);
        end
        handshake();
        chk("stall_in_trap", {31'b0, in_trap}, 32'h1);
        do_mret();
        chk("stall_mret", {31'b0, in_trap}, 32'h0);

        // Reset while a request is pending, with ready on the same edge
        do_reset();
        sw_irq = 1'b1; mie = 32'h8; mstatus_mie = 1'b1;
        repeat (2) tick();
        chk("midrst_pre_valid", {31'b0, irq_valid}, 32'h1);
        srst = 1'b0; irq_ready = 1'b1;
        tick();
        chk("midrst_valid", {31'b0, irq_valid}, 32'h0);
        chk("midrst_in_trap", {31'b0, in_trap}, 32'h0);
        chk("midrst_count", irq_count, 32'h0);
        srst = 1'b1; irq_ready = 1'b0; sw_irq = 1'b0;
        repeat (3) tick();

        // Counter wrap via preload, then mret in IDLE
        sw_irq = 1'b1;
        repeat (2) tick();
        force dut.irq_count_q = 32'hFFFF_FFFF;
        m_count = 32'hFFFF_FFFF;
        #1 release dut.irq_count_q;
        sw_irq = 1'b0;
        handshake();
        chk("wrap_count", irq_count, 32'h0);
        chk("wrap_in_trap", {31'b0, in_trap}, 32'h1);
        do_mret();
        repeat (2) tick();
        do_mret();
        chk("idle_mret_trap", {31'b0, in_trap}, 32'h0);
        chk("idle_mret_valid", {31'b0, irq_valid}, 32'h0);
        chk("idle_mret_count", irq_count, 32'h0);

        // Random traffic against the model
        do_reset();
        mstatus_mie = 1'b1;
        for (int i = 0; i < 600; i++) begin
            if ((i % 32) == 0) mie = $urandom & 32'h888;
            if ($urandom_range(0, 7) == 0) sw_irq = ~sw_irq;
            if ($urandom_range(0, 7) == 0) timer_irq = ~timer_irq;
            if ($urandom_range(0, 7) == 0) ext_irq = ~ext_irq;
            if ($urandom_range(0, 15) == 0) mstatus_mie = ~mstatus_mie;
            irq_ready = 1'($urandom_range(0, 1));
            mret = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 199) == 0) srst = 1'b0;
            else srst = 1'b1;
            tick();
        end
        srst = 1'b1; irq_ready = 1'b0; mret = 1'b0;
        repeat (3) tick();

        chk("scoreboard_empty", exp_q.size(), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
